// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the multiplier issue arbiter.
// Holds the default pipeline latency and tag width, the source-port
// encoding, and the layout of one tracking-pipe entry.
package mul_arb_pkg;

  // Cycles from the issue edge to the result-valid edge (multiplier IP is LAT-1).
  localparam int LAT_DEF   = 7;
  // Width of the destination tag carried with each operation.
  localparam int TAG_W_DEF = 4;

  // Which requester an in-flight operation belongs to.
  typedef enum logic {
    SRC_P0 = 1'b0,
    SRC_P1 = 1'b1
  } src_e;

  // One tracking-pipe entry at the default tag width.
  typedef struct packed {
    logic                 valid;
    src_e                 src;
    logic [TAG_W_DEF-1:0] tag;
  } trk_entry_t;

endpackage

// File: rtl/mul_track_pipe.sv
// LAT-deep shift register of {valid, src, tag} that travels alongside the
// multiplier pipeline. clear_i drops every valid bit at the next edge
// (mispredict recovery); rst_n clears everything asynchronously.
module mul_track_pipe
  import mul_arb_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  src_e             in_src_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  output src_e             out_src_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             any_valid_o
);

  logic [LAT-1:0]            valid_q, valid_d;
  logic [LAT-1:0]            src_q, src_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;

  // Next state: shift every stage by one; clear kills all valid bits.
  always_comb begin
    valid_d = {valid_q[LAT-2:0], in_valid_i};
    src_d   = {src_q[LAT-2:0], logic'(in_src_i)};
    tag_d   = {tag_q[LAT-2:0], in_tag_i};
    if (clear_i) begin
      valid_d = '0;
    end
  end

  // Pipe registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      src_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_src_o   = src_e'(src_q[LAT-1]);
  assign out_tag_o   = tag_q[LAT-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/mul_issue_arb.sv
// Two-port issue arbiter and result router for the shared pipelined
// multiplier. At most one operation issues per cycle; its source port and
// tag ride a LAT-deep tracking pipe so the result returns to the issuing
// port exactly LAT cycles later.
//
// Handshake: a request transfers at a rising edge where reqN_valid and
// reqN_ready are both high; ready never depends on the requester holding
// valid for more than the current cycle, and results carry no backpressure.
//
// Build option MUL_ARB_RR_EN: defined gives round-robin between the ports
// (port 0 wins the first contest); undefined gives fixed priority to port 0
// and removes the last-grant register.
module mul_issue_arb
  import mul_arb_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_p,
  output logic             res0_valid,
  output logic [31:0]      res0_data,
  output logic [TAG_W-1:0] res0_tag,
  output logic             res1_valid,
  output logic [31:0]      res1_data,
  output logic [TAG_W-1:0] res1_tag,
  output logic             busy
);

  logic             hs0, hs1, issue;
  src_e             grant_src;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [TAG_W-1:0] in_tag;
  logic             trk_valid;
  src_e             trk_src;
  logic [TAG_W-1:0] trk_tag;
  logic             trk_any;
  logic             unused_hi;

  assign hs0       = req0_valid & req0_ready;
  assign hs1       = req1_valid & req1_ready;
  assign issue     = hs0 | hs1;
  assign grant_src = hs1 ? SRC_P1 : SRC_P0;

`ifdef MUL_ARB_RR_EN
  src_e last_q, last_d;

  // Grant: a lone requester wins; in a contest the port not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !flush) begin
      if (req0_valid && req1_valid) begin
        req0_ready = (last_q == SRC_P1);
        req1_ready = (last_q == SRC_P0);
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Last-grant pointer moves only on a completed handshake.
  always_comb begin
    last_d = last_q;
    if (issue) begin
      last_d = grant_src;
    end
  end

  // Last-grant register; resets to port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_P1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Grant: fixed priority, port 0 always wins a contest.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !flush) begin
      req0_ready = req0_valid;
      req1_ready = req1_valid & ~req0_valid;
    end
  end
`endif

  // Operand capture: take the granted operands on issue, otherwise hold.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    in_tag  = '0;
    if (issue) begin
      mul_a_d = hs1 ? req1_a : req0_a;
      mul_b_d = hs1 ? req1_b : req0_b;
      in_tag  = hs1 ? req1_tag : req0_tag;
    end
  end

  // Operand registers feeding the multiplier; flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  mul_track_pipe #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_track (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush),
    .in_valid_i  (issue),
    .in_src_i    (grant_src),
    .in_tag_i    (in_tag),
    .out_valid_o (trk_valid),
    .out_src_o   (trk_src),
    .out_tag_o   (trk_tag),
    .any_valid_o (trk_any)
  );

  // Result routing: the last pipe stage selects the port; flush suppresses it.
  assign res0_valid = trk_valid & (trk_src == SRC_P0) & ~flush;
  assign res1_valid = trk_valid & (trk_src == SRC_P1) & ~flush;
  assign res0_tag   = trk_tag;
  assign res1_tag   = trk_tag;
  assign res0_data  = mul_p[31:0];
  assign res1_data  = mul_p[31:0];
  assign busy       = trk_any;

  // Only the low half of the product is returned.
  assign unused_hi  = ^mul_p[63:32];

endmodule

// File: doc/mul_issue_arb.md
# mul_issue_arb

Two-port issue arbiter and result router for the shared pipelined 32-bit multiplier in the out-of-order core. It accepts multiply operations from two requesters (e.g. two reservation stations) over valid/ready handshakes, issues at most one per cycle into the multiplier, and tracks source and tag alongside the multiplier pipeline. Each result returns to the port that issued it, with its tag, exactly LAT cycles after issue. It replaces per-port busy shift registers, so both ports can keep the multiplier full at one issue per cycle.

## Interface
- LAT, 7, cycles from the issue edge to the result-valid edge; ≥2; the multiplier IP latency is LAT-1.
- TAG_W, 4, width of the tag carried with each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill all in-flight operations (mispredict recovery).
- req0_valid, req1_valid  in  1  operation offered on port 0 / port 1.
- req0_ready, req1_ready  out  1  handshake grant; at most one is high per cycle.
- req0_a, req0_b, req1_a, req1_b  in  32  operands.
- req0_tag, req1_tag  in  TAG_W  destination tag.
- mul_a, mul_b  out  32  registered operands to the multiplier.
- mul_p  in  64  multiplier product, valid LAT-1 cycles after mul_a/mul_b change.
- res0_valid, res1_valid  out  1  result strobe per port.
- res0_data, res1_data  out  32  equal to mul_p[31:0] (low half; sign-agnostic).
- res0_tag, res1_tag  out  TAG_W  tag of the returning operation.
- busy  out  1  any operation in flight.

## Operation
- Grant logic: when exactly one port is valid, that port gets ready. When both are valid, the port not most recently granted gets ready (round-robin). The last-grant pointer updates only on a completed handshake; its reset value is 1, so port 0 wins the first contest.
- A handshake is valid&ready at a rising edge. On a handshake, mul_a/mul_b take the granted operands, and stage 0 of the tracking pipe gets {valid=1, src, tag}. With no handshake, mul_a/mul_b hold and stage 0 valid is 0.
- The tracking pipe is a LAT-deep shift register of {valid, src, tag}. The last stage drives the result: resN_valid = last.valid & (last.src==N) & ~flush. resN_tag = last.tag. res0_data = res1_data = mul_p[31:0].
- Results have no backpressure. Consumers (the CDB) must accept them in the cycle shown. No result collisions can occur because at most one operation issues per cycle.
- flush: forces both readies to 0 and gates both resN_valid to 0 in that cycle. At the edge it clears every pipe valid bit. mul_a/mul_b hold their values.
- busy = OR of all pipe valid bits.

## Timing
- Issue at edge T gives resN_valid high for the single cycle after edge T+LAT-1 (sampled at edge T+LAT). Fixed latency, no variation.
- Throughput is one issue per cycle. Back-to-back issues return in back-to-back cycles, in issue order.
- req_ready is combinational from req_valid, the pointer, and flush. No combinational path from req_* to res_*.
- Reset values: pipe valids 0, mul_a=mul_b=0, pointer=1, all resN_valid/resN_tag 0, busy 0. Readies are 0 while rst_n is low.
- Reset mid-operation drops all in-flight operations. No result emerges after release. The first grant after release goes to port 0 if both ports are valid.
- flush coinciding with a request: no grant. flush coinciding with a result in the last stage: result is suppressed.
- flush coinciding with the first cycle after reset release: no effect beyond blocking the grant.

## Configuration
- MUL_ARB_RR_EN defined: round-robin arbitration as above.
- MUL_ARB_RR_EN undefined: fixed priority, port 0 always wins a contest. The pointer register is removed, and port 1 can be starved.

## Structure
- Package mul_arb_pkg holds:
  - the LAT and TAG_W defaults;
  - the src encoding (SRC_P0=0, SRC_P1=1);
  - the packed struct for a tracking-pipe entry {valid, src, tag}.
- Sub-module mul_track_pipe is the LAT-deep entry shift register with synchronous clear (flush) and asynchronous reset.
- The arbiter owns the grant logic, the operand registers and the output decode.

## Test plan
- Port 0 only, a=3, b=5, tag=2, issued at edge 10 → res0_valid at edge 17 with data 15, tag 2. res1_valid stays 0 and busy is high for edges 10–16.
- Both ports valid every cycle (p0: a=2,b=i; p1: a=3,b=i) → grants alternate starting with port 0. Results alternate ports in consecutive cycles with the correct products.
- Operands 0xFFFFFFFF × 0xFFFFFFFF → data 0x00000001. 0x10000 × 0x10000 → data 0x00000000.
- Four issues on edges 20–23, flush high during the cycle before edge 22 → no ready in that cycle, no results ever appear for edges 20–21. The edge-23 issue returns at edge 30.
- rst_n pulsed low mid-flight with three operations pending → outputs 0 immediately, no stale results. With both ports valid after release, port 0 is granted first.
- MUL_ARB_RR_EN undefined, both ports valid for 8 cycles → port 0 gets all 8 grants and req1_ready stays 0.
